button_conditioner: RTL and testbench

Parametrised multi-channel button conditioner for the clock's set inputs. Each channel is synchronised into `i_clk` and sampled on the shared debounce strobe from `clk_gen`. A channel's debounced level changes only after `NUM_SAMPLES` consecutive disagreeing samples, so hysteresis is symmetric for press and release. The block also emits single-cycle press and release pulses and, optionally, hold-to-repeat press pulses. It replaces the fixed three-input `button_debounce` between the pad inputs and the time-set logic.

---
 rtl/clock_pkg.sv | 27 ++
 rtl/debounce_channel.sv | 159 +++++++++++++++
 rtl/button_conditioner.sv | 63 ++++++
 tb/tb_button_conditioner.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared constants and types for the clock's button front end.
//   DEBOUNCE_SAMPLES   - default consecutive samples needed to change a debounced level
//   REPEAT_DELAY_STB   - default strobes of hold before the first repeat press
//   REPEAT_PERIOD_STB  - default strobes between later repeat presses
//   BTN_*              - channel index of each set button on the button bus
package clock_pkg;

  localparam int unsigned DEBOUNCE_SAMPLES  = 5;
  localparam int unsigned REPEAT_DELAY_STB  = 2000;
  localparam int unsigned REPEAT_PERIOD_STB = 500;

  localparam int unsigned NUM_BUTTONS     = 3;
  localparam int unsigned BTN_FAST_SET    = 0;
  localparam int unsigned BTN_SET_HOURS   = 1;
  localparam int unsigned BTN_SET_MINUTES = 2;

  // Debounced channel state; the encoding doubles as the level output.
  typedef enum logic {
    CH_IDLE = 1'b0,
    CH_HELD = 1'b1
  } btn_state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-FF synchroniser, symmetric debounce counter,
// IDLE/HELD state, press/release pulses and optional hold-to-repeat.
// Optional feature macro: BUTTON_REPEAT_EN (repeat presses while held).
// Ports:
//   i_clk, i_reset_n  - clock, synchronous active-low reset
//   i_debounce_stb    - one-cycle sample strobe
//   i_button          - raw asynchronous pad level
//   o_level           - debounced level, 1 = pressed
//   o_press           - one-cycle press pulse (and repeat pulses when enabled)
//   o_release         - one-cycle release pulse
//   o_press_nxt_c     - combinational value o_press takes on the next edge
module debounce_channel
  import clock_pkg::*;
#(
  parameter int unsigned NUM_SAMPLES   = DEBOUNCE_SAMPLES,
  parameter bit          INVERT        = 1'b0,
  parameter int unsigned REPEAT_DELAY  = REPEAT_DELAY_STB,
  parameter int unsigned REPEAT_PERIOD = REPEAT_PERIOD_STB
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_debounce_stb,
  input  logic i_button,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_press_nxt_c
);

  localparam int unsigned CNT_W = $clog2(NUM_SAMPLES + 1);

  // Zero counts are meaningless; this block only exists in a misconfigured build.
  if (NUM_SAMPLES == 0 || REPEAT_DELAY == 0 || REPEAT_PERIOD == 0) begin : g_bad_params
  end

  logic             r_sync1;
  logic             r_sync2;
  logic             w_s;
  btn_state_e       r_state;
  btn_state_e       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             r_press;
  logic             r_release;
  logic             w_press_nxt;
  logic             w_release_nxt;

  // Synchroniser resets to the inactive pad level so w_s starts at 0.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_sync1 <= INVERT;
      r_sync2 <= INVERT;
    end else begin
      r_sync1 <= i_button;
      r_sync2 <= r_sync1;
    end
  end

  assign w_s       = r_sync2 ^ INVERT;
  assign w_cnt_inc = r_cnt + CNT_W'(1);

  // Debounce next-state: disagreeing samples accumulate, any agreeing sample clears.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_press_nxt   = 1'b0;
    w_release_nxt = 1'b0;
    if (i_debounce_stb) begin
      if (w_s == o_level) begin
        w_cnt_nxt = '0;
      end else if (w_cnt_inc == CNT_W'(NUM_SAMPLES)) begin
        w_cnt_nxt = '0;
        case (r_state)
          CH_IDLE: begin
            w_state_nxt = CH_HELD;
            w_press_nxt = 1'b1;
          end
          CH_HELD: begin
            w_state_nxt   = CH_IDLE;
            w_release_nxt = 1'b1;
          end
          default: w_state_nxt = CH_IDLE;
        endcase
      end else begin
        w_cnt_nxt = w_cnt_inc;
      end
    end
  end

`ifdef BUTTON_REPEAT_EN
  localparam int unsigned RPT_W = $clog2(max_u(REPEAT_DELAY, REPEAT_PERIOD) + 1);

  logic [RPT_W-1:0] r_rpt;
  logic [RPT_W-1:0] w_rpt_nxt;
  logic [RPT_W-1:0] w_rpt_inc;
  logic [RPT_W-1:0] w_rpt_tgt;
  logic             r_rpt_armed;
  logic             w_rpt_armed_nxt;
  logic             w_rpt_pulse;

  assign w_rpt_inc = r_rpt + RPT_W'(1);
  // First interval is the initial delay, every later one the repeat period.
  assign w_rpt_tgt = r_rpt_armed ? RPT_W'(REPEAT_PERIOD) : RPT_W'(REPEAT_DELAY);

  // Repeat timer only runs while staying HELD; a coincident release wins.
  always_comb begin
    w_rpt_nxt       = r_rpt;
    w_rpt_armed_nxt = r_rpt_armed;
    w_rpt_pulse     = 1'b0;
    if (r_state != CH_HELD || w_state_nxt != CH_HELD) begin
      w_rpt_nxt       = '0;
      w_rpt_armed_nxt = 1'b0;
    end else if (i_debounce_stb) begin
      if (w_rpt_inc == w_rpt_tgt) begin
        w_rpt_nxt       = '0;
        w_rpt_armed_nxt = 1'b1;
        w_rpt_pulse     = 1'b1;
      end else begin
        w_rpt_nxt = w_rpt_inc;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_rpt       <= '0;
      r_rpt_armed <= 1'b0;
    end else begin
      r_rpt       <= w_rpt_nxt;
      r_rpt_armed <= w_rpt_armed_nxt;
    end
  end

  assign o_press_nxt_c = w_press_nxt | w_rpt_pulse;
`else
  assign o_press_nxt_c = w_press_nxt;
`endif

  // State, counter and pulse registers.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state   <= CH_IDLE;
      r_cnt     <= '0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_press   <= o_press_nxt_c;
      r_release <= w_release_nxt;
    end
  end

  assign o_level   = (r_state == CH_HELD);
  assign o_press   = r_press;
  assign o_release = r_release;

endmodule

// File: rtl/button_conditioner.sv
// Multi-channel button conditioner: one debounce_channel per pad plus a
// registered OR of all press pulses.
// Optional feature macro: BUTTON_REPEAT_EN (hold-to-repeat press pulses).
// Ports:
//   i_clk, i_reset_n  - clock, synchronous active-low reset
//   i_debounce_stb    - shared one-cycle sample strobe
//   i_buttons         - raw asynchronous pad levels
//   o_level           - debounced levels, 1 = pressed
//   o_press           - one-cycle press (and repeat) pulses
//   o_release         - one-cycle release pulses
//   o_any_press       - OR of o_press, same cycle
module button_conditioner
  import clock_pkg::*;
#(
  parameter int unsigned                NUM_CHANNELS  = NUM_BUTTONS,
  parameter int unsigned                NUM_SAMPLES   = DEBOUNCE_SAMPLES,
  parameter logic [NUM_CHANNELS-1:0]    INVERT_MASK   = '0,
  parameter int unsigned                REPEAT_DELAY  = REPEAT_DELAY_STB,
  parameter int unsigned                REPEAT_PERIOD = REPEAT_PERIOD_STB
) (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  input  logic                    i_debounce_stb,
  input  logic [NUM_CHANNELS-1:0] i_buttons,
  output logic [NUM_CHANNELS-1:0] o_level,
  output logic [NUM_CHANNELS-1:0] o_press,
  output logic [NUM_CHANNELS-1:0] o_release,
  output logic                    o_any_press
);

  logic [NUM_CHANNELS-1:0] w_press_nxt;
  logic                    r_any_press;

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
    debounce_channel #(
      .NUM_SAMPLES   (NUM_SAMPLES),
      .INVERT        (INVERT_MASK[c]),
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD)
    ) u_ch (
      .i_clk          (i_clk),
      .i_reset_n      (i_reset_n),
      .i_debounce_stb (i_debounce_stb),
      .i_button       (i_buttons[c]),
      .o_level        (o_level[c]),
      .o_press        (o_press[c]),
      .o_release      (o_release[c]),
      .o_press_nxt_c  (w_press_nxt[c])
    );
  end

  // Registered from the channels' next-press values so it aligns with o_press.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_any_press <= 1'b0;
    end else begin
      r_any_press <= |w_press_nxt;
    end
  end

  assign o_any_press = r_any_press;

endmodule

// File: tb/tb_button_conditioner.sv
module tb_button_conditioner;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       stb;
  logic [2:0] buttons;
  logic [2:0] level;
  logic [2:0] press;
  logic [2:0] rel;
  logic       any_press;

  always #5 clk = ~clk;

  button_conditioner #(
    .NUM_CHANNELS  (3),
    .NUM_SAMPLES   (5),
    .INVERT_MASK   (3'b000),
    .REPEAT_DELAY  (4),
    .REPEAT_PERIOD (2)
  ) dut (
    .i_clk          (clk),
    .i_reset_n      (reset_n),
    .i_debounce_stb (stb),
    .i_buttons      (buttons),
    .o_level        (level),
    .o_press        (press),
    .o_release      (rel),
    .o_any_press    (any_press)
  );

  typedef struct packed {
    logic [2:0] lvl;
    logic [2:0] press;
    logic [2:0] rel;
  } exp_t;

  exp_t       sb_q[$];
  int         checks = 0;
  int         errors = 0;
  logic [2:0] last_lvl = 3'b000;
  int         hold_cnt[3] = '{default: 0};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check3(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Change pads and wait out the two-flop synchroniser.
  task automatic set_buttons(input logic [2:0] v);
    buttons = v;
    tick();
    tick();
  endtask

  // One strobe: push expectation, strobe, pop and compare, then confirm pulses drop.
  task automatic do_stb(input string tag, input logic [2:0] lvl,
                        input logic [2:0] prs, input logic [2:0] rls);
    exp_t       e;
    logic [2:0] p;
    p = prs;
`ifdef BUTTON_REPEAT_EN
    // Repeat presses land 4, 6, 8, ... strobes after qualification while still held.
    for (int c = 0; c < 3; c++) begin
      if (last_lvl[c] && lvl[c]) begin
        hold_cnt[c]++;
        if (hold_cnt[c] >= 4 && ((hold_cnt[c] - 4) % 2) == 0) p[c] = 1'b1;
      end else begin
        hold_cnt[c] = 0;
      end
    end
`endif
    last_lvl = lvl;
    e.lvl    = lvl;
    e.press  = p;
    e.rel    = rls;
    sb_q.push_back(e);
    stb = 1'b1;
    tick();
    stb = 1'b0;
    e = sb_q.pop_front();
    check3({tag, ".level"}, level, e.lvl);
    check3({tag, ".press"}, press, e.press);
    check3({tag, ".release"}, rel, e.rel);
    check1({tag, ".any"}, any_press, |e.press);
    tick();
    check3({tag, ".press_drop"}, press, 3'b000);
    check3({tag, ".release_drop"}, rel, 3'b000);
    check1({tag, ".any_drop"}, any_press, 1'b0);
    tick();
    tick();
  endtask

  // n strobes with no expected change, then one qualifying strobe.
  task automatic qualify(input string tag, input logic [2:0] lvl_before,
                         input logic [2:0] lvl_after, input logic [2:0] prs,
                         input logic [2:0] rls, input int n);
    for (int i = 0; i < n; i++) do_stb({tag, ".wait"}, lvl_before, 3'b000, 3'b000);
    do_stb({tag, ".edge"}, lvl_after, prs, rls);
  endtask

  initial begin
    // Reset with all pads pressed; strobes during reset must be ignored.
    reset_n = 1'b0;
    stb     = 1'b0;
    buttons = 3'b111;
    tick();
    tick();
    stb = 1'b1;
    tick();
    tick();
    stb = 1'b0;
    tick();
    check3("rst.level", level, 3'b000);
    check3("rst.press", press, 3'b000);
    check3("rst.release", rel, 3'b000);
    check1("rst.any", any_press, 1'b0);
    reset_n = 1'b1;
    tick();
    tick();
    qualify("rst_press", 3'b000, 3'b111, 3'b111, 3'b000, 4);

    // Release everything.
    set_buttons(3'b000);
    qualify("rel_all", 3'b111, 3'b000, 3'b000, 3'b111, 4);

    // ch0 bounces every 3 strobes, never reaching 5 in a row.
    for (int k = 0; k < 30; k++) begin
      if (k % 3 == 0) set_buttons(((k / 3) % 2 == 0) ? 3'b001 : 3'b000);
      do_stb("bounce", 3'b000, 3'b000, 3'b000);
    end
    set_buttons(3'b001);
    qualify("bounce_settle", 3'b000, 3'b001, 3'b001, 3'b000, 4);

    // ch1 press, then release with a one-strobe glitch after 3 samples.
    set_buttons(3'b011);
    qualify("ch1_press", 3'b001, 3'b011, 3'b010, 3'b000, 4);
    set_buttons(3'b001);
    for (int i = 0; i < 3; i++) do_stb("ch1_pre_glitch", 3'b011, 3'b000, 3'b000);
    set_buttons(3'b011);
    do_stb("ch1_glitch", 3'b011, 3'b000, 3'b000);
    set_buttons(3'b001);
    qualify("ch1_release", 3'b011, 3'b001, 3'b000, 3'b010, 4);

    set_buttons(3'b000);
    qualify("ch0_release", 3'b001, 3'b000, 3'b000, 3'b001, 4);

    // ch0 and ch2 pressed together.
    set_buttons(3'b101);
    qualify("simul", 3'b000, 3'b101, 3'b101, 3'b000, 4);

    // Keep ch2 held 12 strobes past qualification while ch0 releases.
    set_buttons(3'b100);
    qualify("hold_ch0_rel", 3'b101, 3'b100, 3'b000, 3'b001, 4);
    for (int i = 0; i < 7; i++) do_stb("hold_ch2", 3'b100, 3'b000, 3'b000);
    set_buttons(3'b000);
    qualify("ch2_release", 3'b100, 3'b000, 3'b000, 3'b100, 4);

    // Reset after 4 of 5 samples discards progress.
    set_buttons(3'b010);
    for (int i = 0; i < 4; i++) do_stb("midrst_pre", 3'b000, 3'b000, 3'b000);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check3("midrst.level", level, 3'b000);
    check3("midrst.press", press, 3'b000);
    check1("midrst.any", any_press, 1'b0);
    tick();
    tick();
    qualify("midrst_requal", 3'b000, 3'b010, 3'b010, 3'b000, 4);

    check1("sb_empty", (sb_q.size() == 0), 1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
